spi_master: RTL and testbench

SPI bus master (mode 0: CPOL=0, CPHA=0, MSB first) that runs 8-bit full-duplex transfers with one slave.
- Generates sclk, ss_n and mosi from the system clock; samples miso.
- It is the initiator end of the bus that spi_slave responds to.
- The host side uses a start/busy/done handshake with parallel tx/rx bytes.

---
 rtl/spi_pkg.sv | 25 ++
 rtl/spi_clk_gen.sv | 55 +++++
 rtl/spi_master.sv | 158 +++++++++++++++
 tb/tb_spi_master.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master/slave pair: data width, bus mode
// constants and the master FSM state encoding.
package spi_pkg;

  localparam int SPI_DATA_W = 8;

  // Mode 0: sclk idles low, data sampled on the rising edge.
  localparam bit CPOL = 1'b0;
  localparam bit CPHA = 1'b0;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_XFER  = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    SETUP = ST_SETUP,
    XFER  = ST_XFER,
    HOLD  = ST_HOLD,
    GAP   = ST_GAP
  } spi_state_e;

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period counter that produces the registered serial clock and
// one-cycle strobes marking the clk edge on which sclk rises or falls.
// A strobe is high in the cycle whose closing clk edge changes sclk.
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,         // count and toggle while high; idle low otherwise
  input  logic hold_low,   // suppress the next 0->1 toggle (final low phase)
  output logic sclk,
  output logic rise_tick,
  output logic fall_tick
);

  logic [7:0] cnt_q, cnt_d;
  logic       sclk_q, sclk_d;
  logic       period_end;

  assign period_end = en && (cnt_q == 8'(CLK_DIV - 1));
  assign rise_tick  = period_end && !sclk_q;
  assign fall_tick  = period_end && sclk_q;
  assign sclk       = sclk_q;

  // Next half-period count and sclk level.
  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (!en) begin
      cnt_d  = 8'd0;
      sclk_d = CPOL;
    end else if (period_end) begin
      cnt_d = 8'd0;
      if (!(rise_tick && hold_low)) begin
        sclk_d = ~sclk_q;
      end
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Counter and sclk registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= 8'd0;
      sclk_q <= CPOL;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master: one 8-bit full-duplex transfer per accepted start.
// Host handshake: start is sampled only while busy=0; the accepting edge
// latches tx_data and raises busy. done pulses for one cycle together with
// the rx_data update; busy stays high until the post-transfer gap elapses.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [SPI_DATA_W-1:0] tx_data,
  output logic [SPI_DATA_W-1:0] rx_data,
  output logic                  busy,
  output logic                  done,
  output logic                  sclk,
  output logic                  ss_n,
  output logic                  mosi,
  input  logic                  miso,
  output spi_state_e            dbg_state
);

  spi_state_e            state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [SPI_DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [SPI_DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [SPI_DATA_W-1:0] rx_data_q, rx_data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  ss_n_q, ss_n_d;

  logic clk_en;
  logic rise_tick;
  logic fall_tick;

  // The setup phase is the first low half-period of the generator, so it
  // runs through SETUP and XFER; after bit 8 the next rise is suppressed
  // and its tick only marks the end of the trailing low half-period.
  assign clk_en = (state_q == SETUP) || (state_q == XFER);

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk       (clk),
    .rst       (rst),
    .en        (clk_en),
    .hold_low  (bit_cnt_q == 4'd8),
    .sclk      (sclk),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  assign rx_data   = rx_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ss_n      = ss_n_q;
  assign mosi      = tx_shift_q[SPI_DATA_W-1];
  assign dbg_state = state_q;

  // Next-state and datapath updates for the transfer sequence.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_cnt_d  = bit_cnt_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ss_n_d     = ss_n_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          tx_shift_d = tx_data;
          rx_shift_d = '0;
          bit_cnt_d  = 4'd0;
          cnt_d      = 8'd0;
          ss_n_d     = 1'b0;
          busy_d     = 1'b1;
          state_d    = SETUP;
        end
      end
      SETUP: begin
        if (rise_tick) begin
          rx_shift_d = {rx_shift_q[SPI_DATA_W-2:0], miso};
          bit_cnt_d  = 4'd1;
          state_d    = XFER;
        end
      end
      XFER: begin
        if (rise_tick) begin
          if (bit_cnt_q == 4'd8) begin
            cnt_d   = 8'd0;
            state_d = HOLD;
          end else begin
            rx_shift_d = {rx_shift_q[SPI_DATA_W-2:0], miso};
            bit_cnt_d  = bit_cnt_q + 4'd1;
          end
        end
        if (fall_tick && (bit_cnt_q < 4'd8)) begin
          tx_shift_d = {tx_shift_q[SPI_DATA_W-2:0], 1'b0};
        end
      end
      HOLD: begin
        if (cnt_q == 8'(CLK_DIV - 1)) begin
          cnt_d     = 8'd0;
          ss_n_d    = 1'b1;
          rx_data_d = rx_shift_q;
          done_d    = 1'b1;
          state_d   = GAP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      GAP: begin
        if (cnt_q == 8'(CS_GAP - 1)) begin
          cnt_d   = 8'd0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters, shift registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      bit_cnt_q  <= 4'd0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ss_n_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ss_n_q     <= ss_n_d;
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master with a behavioural mode-0 slave on the bus.
// Cycle numbering: start is driven high in cycle 0, registered effects of
// the accepting edge appear in cycle 1; outputs are sampled on negedge.
module tb_spi_master;
  import spi_pkg::*;

  localparam int CD    = 4;
  localparam int GAP_C = 2;
  localparam int LIMIT = 20 * CD + 40;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       busy, done, sclk, ss_n, mosi, miso;
  spi_state_e dbg_state;

  spi_master #(
    .CLK_DIV (CD),
    .CS_GAP  (GAP_C)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .tx_data   (tx_data),
    .rx_data   (rx_data),
    .busy      (busy),
    .done      (done),
    .sclk      (sclk),
    .ss_n      (ss_n),
    .mosi      (mosi),
    .miso      (miso),
    .dbg_state (dbg_state)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  // ---------------- behavioural slave ----------------
  logic [7:0] slave_tx = 8'h00;
  logic [7:0] slave_rx = 8'h00;
  int   s_idx = 0;
  int   s_rises = 0;
  int   ss_low_cnt = 0;
  int   done_total = 0;
  logic sclk_prev = 1'b0;
  logic ss_prev = 1'b1;

  initial miso = 1'b0;

  always @(negedge clk) begin
    if (done === 1'b1) done_total++;
    if (ss_n === 1'b0 && ss_prev === 1'b1) begin
      slave_rx   = 8'h00;
      s_rises    = 0;
      ss_low_cnt = 0;
      s_idx      = 0;
    end
    if (ss_n !== 1'b0) begin
      s_idx = 0;
      miso  = slave_tx[7];
    end else begin
      ss_low_cnt++;
      if (sclk === 1'b1 && sclk_prev === 1'b0) begin
        slave_rx = {slave_rx[6:0], mosi};
        s_idx++;
        s_rises++;
      end else if (sclk === 1'b0 && sclk_prev === 1'b1 && s_idx < 8) begin
        miso = slave_tx[7 - s_idx];
      end
    end
    sclk_prev = sclk;
    ss_prev   = ss_n;
  end

  // ---------------- checker ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Runs one transfer from idle; optionally pulses start again at cycle
  // poke_at while the transfer is in flight. Returns at the done negedge.
  task automatic run_xfer(input logic [7:0] tx, input logic [7:0] stx, input int poke_at,
                          output int rise_at, output int done_at);
    slave_tx = stx;
    tx_data  = tx;
    @(negedge clk);
    start   = 1'b1;
    rise_at = -1;
    done_at = -1;
    for (int n = 1; n <= LIMIT; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start   = 1'b0;
        tx_data = ~tx;
        check("busy_after_accept", busy, 1);
        check("ss_n_low_after_accept", ss_n, 0);
        check("mosi_msb_in_setup", mosi, tx[7]);
      end
      if (n == poke_at) begin
        start   = 1'b1;
        tx_data = 8'h00;
      end
      if (n == poke_at + 1) start = 1'b0;
      if (sclk === 1'b1 && rise_at < 0) rise_at = n;
      if (done === 1'b1) begin
        done_at = n;
        break;
      end
    end
    if (done_at < 0) check("done_timeout", 0, 1);
  endtask

  // From the done cycle, count cycles until busy drops.
  task automatic check_gap();
    int k;
    k = -1;
    for (int i = 1; i <= GAP_C + 10; i++) begin
      @(negedge clk);
      if (i == 1) check("done_single_cycle", done, 0);
      if (busy === 1'b0) begin
        k = i;
        break;
      end
    end
    check("busy_low_after_gap", k, GAP_C);
  endtask

  task automatic wait_done(output int n_out);
    n_out = -1;
    for (int n = 1; n <= LIMIT; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        n_out = n;
        break;
      end
    end
    if (n_out < 0) check("wait_done_timeout", 0, 1);
  endtask

  typedef struct {
    logic [7:0] tx;
    logic [7:0] stx;
    logic [7:0] exp_rx;
    logic [7:0] exp_srx;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int rise_at, done_at, dt, hi, rises, nd;
    logic prev;
    bit saw_low;

    vecs[0] = '{tx: 8'hA5, stx: 8'h3C, exp_rx: 8'h3C, exp_srx: 8'hA5};
    vecs[1] = '{tx: 8'h00, stx: 8'hFF, exp_rx: 8'hFF, exp_srx: 8'h00};
    vecs[2] = '{tx: 8'h80, stx: 8'h55, exp_rx: 8'h55, exp_srx: 8'h80};
    vecs[3] = '{tx: 8'hC3, stx: 8'h0F, exp_rx: 8'h0F, exp_srx: 8'hC3};

    rst     = 1'b1;
    start   = 1'b0;
    tx_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_sclk", sclk, 0);
    check("rst_ss_n", ss_n, 1);
    check("rst_mosi", mosi, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_state", dbg_state, ST_IDLE);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Table-driven transfers with full timing checks.
    foreach (vecs[i]) begin
      exp_q.push_back(vecs[i].exp_rx);
      run_xfer(vecs[i].tx, vecs[i].stx, -1, rise_at, done_at);
      check("rx_data", rx_data, exp_q.pop_front());
      check("slave_rx", slave_rx, vecs[i].exp_srx);
      check("first_rise_cycle", rise_at, 1 + CD);
      check("done_cycle", done_at, 1 + 18 * CD);
      check("ss_n_low_cycles", ss_low_cnt, 18 * CD);
      check("sclk_rises", s_rises, 8);
      check("ss_n_high_at_done", ss_n, 1);
      check("sclk_low_at_done", sclk, 0);
      check_gap();
      repeat (3) @(negedge clk);
    end

    // start while busy is ignored.
    dt = done_total;
    run_xfer(8'h69, 8'h96, 20, rise_at, done_at);
    check("poke_rx_data", rx_data, 8'h96);
    check("poke_slave_rx", slave_rx, 8'h69);
    check_gap();
    saw_low = 1'b0;
    for (int i = 0; i < 4 * CD; i++) begin
      @(negedge clk);
      if (ss_n !== 1'b1) saw_low = 1'b1;
    end
    check("poke_no_second_xfer", saw_low, 0);
    check("poke_single_done", done_total - dt, 1);
    check("poke_rx_held", rx_data, 8'h96);

    // Back-to-back with start held high.
    slave_tx = 8'h5B;
    tx_data  = 8'h01;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    tx_data = 8'h80;
    wait_done(nd);
    check("b2b_first_slave_rx", slave_rx, 8'h01);
    check("b2b_first_rx_data", rx_data, 8'h5B);
    hi = 1;
    for (int i = 0; i < GAP_C + 10; i++) begin
      @(negedge clk);
      if (ss_n === 1'b1) hi++;
      else break;
    end
    check("b2b_ss_n_high_cycles", hi, GAP_C + 1);
    wait_done(nd);
    start = 1'b0;
    check("b2b_second_slave_rx", slave_rx, 8'h80);
    check("b2b_second_rx_data", rx_data, 8'h5B);
    check_gap();
    repeat (3) @(negedge clk);

    // Reset on the 4th sclk rise aborts the transfer.
    slave_tx = 8'hE7;
    tx_data  = 8'h3A;
    @(negedge clk);
    start = 1'b1;
    rises = 0;
    prev  = 1'b0;
    for (int n = 1; n <= LIMIT; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (sclk === 1'b1 && prev === 1'b0) rises++;
      prev = sclk;
      if (rises == 4) break;
    end
    check("rst_mid_reached_rise4", rises, 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    dt = done_total;
    check("abort_ss_n", ss_n, 1);
    check("abort_sclk", sclk, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_rx_data", rx_data, 8'h00);
    check("abort_state", dbg_state, ST_IDLE);
    repeat (20 * CD) @(negedge clk);
    check("abort_no_done", done_total - dt, 0);
    check("abort_ss_n_idle", ss_n, 1);
    run_xfer(8'h5A, 8'h96, -1, rise_at, done_at);
    check("post_abort_rx_data", rx_data, 8'h96);
    check("post_abort_slave_rx", slave_rx, 8'h5A);
    check("post_abort_done_cycle", done_at, 1 + 18 * CD);
    check_gap();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
